axi_lite_slave: RTL and testbench

- AXI4-Lite slave exposing a flat, word-addressed register file of 2^(ADDR_WD-2) words, each DATA_WD bits wide.
- Provides independent read and write channels with byte-strobe writes and an always-OKAY response.
- Sits on a peripheral interconnect as a generic control/status register bank and as the reference slave for interconnect stream tests.

---
 rtl/axi_lite_pkg.sv | 34 +++
 rtl/axi_lite_regfile.sv | 60 ++++++
 rtl/axi_lite_slave.sv | 160 ++++++++++++++++
 tb/tb_axi_lite_slave.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared types, response codes and strobe-merge helper for the AXI4-Lite slave
//
// Purpose: common definitions for axi_lite_slave and axi_lite_regfile.
//   RESP_OKAY / RESP_SLVERR : AXI response encodings.
//   wr_state_e / rd_state_e : write and read channel FSM states.
//   strb_merge()            : byte-wise merge of a new word into an old word,
//                             sized for the widest supported bus (64 bits).
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_COLLECT = 1'b0,  // gathering AW and W into the holding buffers
    WR_RESP    = 1'b1   // write committed, B response outstanding
  } wr_state_e;

  typedef enum logic {
    RD_IDLE  = 1'b0,    // ready for an AR handshake
    RD_VALID = 1'b1     // R beat presented, waiting for rready
  } rd_state_e;

  // Narrower buses zero-extend into the 64-bit arguments and truncate the result.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_word,
                                             input logic [63:0] new_word,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[b*8 +: 8] = strb[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - word-indexed register array with byte-enabled write and registered read
//
// Purpose: storage for axi_lite_slave. NREG words of DATA_WD bits.
// Ports:
//   clk, rstn           : clock, asynchronous active-low reset (clears all words and rd_data)
//   wr_en/wr_idx/wr_data/wr_strb : write port, bytes updated where wr_strb is set
//   rd_en/rd_idx        : read request; rd_data loads on the same edge
//   rd_data             : registered read data, holds until the next rd_en
// A read and write to the same index on one edge returns the pre-write word.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int DATA_WD = 32,
  parameter int ADDR_WD = 8,
  localparam int IDX_WD  = ADDR_WD - $clog2(DATA_WD / 8),
  localparam int NREG    = 1 << IDX_WD,
  localparam int STRB_WD = DATA_WD / 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               wr_en,
  input  logic [IDX_WD-1:0]  wr_idx,
  input  logic [DATA_WD-1:0] wr_data,
  input  logic [STRB_WD-1:0] wr_strb,
  input  logic               rd_en,
  input  logic [IDX_WD-1:0]  rd_idx,
  output logic [DATA_WD-1:0] rd_data
);

  logic [DATA_WD-1:0] mem_q [NREG];
  logic [DATA_WD-1:0] mem_d [NREG];
  logic [DATA_WD-1:0] rd_data_q, rd_data_d;

  always_comb begin
    mem_d     = mem_q;
    rd_data_d = rd_data_q;
    if (wr_en) begin
      mem_d[wr_idx] = DATA_WD'(strb_merge(64'(mem_q[wr_idx]), 64'(wr_data), 8'(wr_strb)));
    end
    // Reads sample mem_q, so a colliding write is not visible until the next read.
    if (rd_en) begin
      rd_data_d = mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_lite_slave.sv
// rtl/axi_lite_slave.sv - AXI4-Lite slave fronting a flat register file
//
// Purpose: AXI4-Lite slave with independent read/write channels, byte-strobe
// writes, one outstanding write and one outstanding read, always-OKAY responses.
// Ports:
//   clk, rstn                         : clock, asynchronous active-low reset
//   s_aw{addr,prot,valid,ready}       : write address channel (prot ignored)
//   s_w{data,strb,valid,ready}        : write data channel
//   s_b{resp,valid,ready}             : write response channel
//   s_ar{addr,prot,valid,ready}       : read address channel (prot ignored)
//   s_r{data,resp,valid,ready}        : read data channel
// All ready/valid outputs come straight from flops.
module axi_lite_slave
  import axi_lite_pkg::*;
#(
  parameter int PERIOD  = 10,
  parameter int DATA_WD = 32,
  parameter int ADDR_WD = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [ADDR_WD-1:0]   s_awaddr,
  input  logic [2:0]           s_awprot,
  input  logic                 s_awvalid,
  output logic                 s_awready,
  input  logic [DATA_WD-1:0]   s_wdata,
  input  logic [DATA_WD/8-1:0] s_wstrb,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  output logic [1:0]           s_bresp,
  output logic                 s_bvalid,
  input  logic                 s_bready,
  input  logic [ADDR_WD-1:0]   s_araddr,
  input  logic [2:0]           s_arprot,
  input  logic                 s_arvalid,
  output logic                 s_arready,
  output logic [DATA_WD-1:0]   s_rdata,
  output logic [1:0]           s_rresp,
  output logic                 s_rvalid,
  input  logic                 s_rready
);

  localparam int OFF     = $clog2(DATA_WD / 8);
  localparam int IDX_WD  = ADDR_WD - OFF;
  localparam int STRB_WD = DATA_WD / 8;

  wr_state_e          wr_state_q, wr_state_d;
  rd_state_e          rd_state_q, rd_state_d;
  logic               aw_held_q, aw_held_d;
  logic [IDX_WD-1:0]  aw_idx_q, aw_idx_d;
  logic               w_held_q, w_held_d;
  logic [DATA_WD-1:0] w_data_q, w_data_d;
  logic [STRB_WD-1:0] w_strb_q, w_strb_d;

  logic               aw_hs, w_hs;
  logic               rf_wr_en, rf_rd_en;
  logic [IDX_WD-1:0]  rf_wr_idx;
  logic [DATA_WD-1:0] rf_wr_data;
  logic [STRB_WD-1:0] rf_wr_strb;

  assign s_awready = !aw_held_q && (wr_state_q == WR_COLLECT);
  assign s_wready  = !w_held_q && (wr_state_q == WR_COLLECT);
  assign s_bvalid  = (wr_state_q == WR_RESP);
  assign s_bresp   = RESP_OKAY;
  assign s_arready = (rd_state_q == RD_IDLE);
  assign s_rvalid  = (rd_state_q == RD_VALID);
  assign s_rresp   = RESP_OKAY;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;

  // The write port always points at the held entry if there is one, otherwise at
  // the bus, so a commit works for any arrival order including same-cycle.
  assign rf_wr_idx  = aw_held_q ? aw_idx_q : s_awaddr[ADDR_WD-1:OFF];
  assign rf_wr_data = w_held_q ? w_data_q : s_wdata;
  assign rf_wr_strb = w_held_q ? w_strb_q : s_wstrb;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    rf_wr_en   = 1'b0;
    if (wr_state_q == WR_COLLECT) begin
      if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
        rf_wr_en   = 1'b1;
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
        wr_state_d = WR_RESP;
      end else begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_idx_d  = s_awaddr[ADDR_WD-1:OFF];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          w_data_d = s_wdata;
          w_strb_d = s_wstrb;
        end
      end
    end else if (s_bready) begin
      wr_state_d = WR_COLLECT;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rf_rd_en   = 1'b0;
    if (rd_state_q == RD_IDLE) begin
      if (s_arvalid) begin
        rf_rd_en   = 1'b1;
        rd_state_d = RD_VALID;
      end
    end else if (s_rready) begin
      rd_state_d = RD_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state_q <= WR_COLLECT;
      rd_state_q <= RD_IDLE;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
    end
  end

  axi_lite_regfile #(
    .DATA_WD (DATA_WD),
    .ADDR_WD (ADDR_WD)
  ) u_regfile (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (rf_wr_en),
    .wr_idx  (rf_wr_idx),
    .wr_data (rf_wr_data),
    .wr_strb (rf_wr_strb),
    .rd_en   (rf_rd_en),
    .rd_idx  (s_araddr[ADDR_WD-1:OFF]),
    .rd_data (s_rdata)
  );

  // Protection bits, sub-word address bits and PERIOD carry no function here.
  logic unused_ok;
  assign unused_ok = ^{s_awprot, s_arprot, s_awaddr[OFF-1:0], s_araddr[OFF-1:0], 32'(PERIOD)};

endmodule

// File: tb/tb_axi_lite_slave.sv
// tb/tb_axi_lite_slave.sv - self-checking bench for axi_lite_slave
module tb_axi_lite_slave;

  localparam int PERIOD = 10;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  s_awaddr, s_araddr;
  logic [2:0]  s_awprot, s_arprot;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;

  int n_pass = 0;
  int n_total = 0;

  always #(PERIOD / 2) clk = ~clk;

  axi_lite_slave #(.PERIOD(PERIOD), .DATA_WD(32), .ADDR_WD(8)) dut (
    .clk(clk), .rstn(rstn),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    s_awaddr = a; s_wdata = d; s_wstrb = s; s_awvalid = 1'b1; s_wvalid = 1'b1;
    n = 0;
    while (!(s_awready && s_wready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wr_ready_timeout", 32'(n < 20), 32'd1);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("wr_bvalid", 32'(s_bvalid), 32'd1);
    chk("wr_bresp", 32'(s_bresp), 32'd0);
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    s_araddr = a; s_arvalid = 1'b1;
    n = 0;
    while (!s_arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rd_ready_timeout", 32'(n < 20), 32'd1);
    @(negedge clk);
    s_arvalid = 1'b0;
    chk("rd_rvalid", 32'(s_rvalid), 32'd1);
    chk("rd_rresp", 32'(s_rresp), 32'd0);
    d = s_rdata;
  endtask

  initial begin
    #(PERIOD * 10000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;

    vecs[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0,        "wr_full_10"};
    vecs[1]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'hDEADBEEF, "rd_full_10"};
    vecs[2]  = '{1'b1, 8'h10, 32'h000000AA, 4'h1, 32'h0,        "wr_b0_10"};
    vecs[3]  = '{1'b1, 8'h10, 32'h55000000, 4'h8, 32'h0,        "wr_b3_10"};
    vecs[4]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'h55ADBEAA, "rd_strb_10"};
    vecs[5]  = '{1'b1, 8'h13, 32'h11223344, 4'h0, 32'h0,        "wr_zero_strb"};
    vecs[6]  = '{1'b0, 8'h12, 32'h0,        4'h0, 32'h55ADBEAA, "rd_after_zero_strb"};
    vecs[7]  = '{1'b1, 8'hFC, 32'hCAFEF00D, 4'hF, 32'h0,        "wr_last_word"};
    vecs[8]  = '{1'b0, 8'hFF, 32'h0,        4'h0, 32'hCAFEF00D, "rd_last_word"};
    vecs[9]  = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h0,        "rd_word0"};
    vecs[10] = '{1'b1, 8'h08, 32'h00000001, 4'hF, 32'h0,        "wr_08"};
    vecs[11] = '{1'b1, 8'h04, 32'hAABBCCDD, 4'h6, 32'h0,        "wr_mid_bytes"};
    vecs[12] = '{1'b0, 8'h04, 32'h0,        4'h0, 32'h00BBCC00, "rd_mid_bytes"};

    rstn = 1'b0;
    s_awaddr = '0; s_awprot = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_araddr = '0; s_arprot = '0; s_arvalid = 1'b0;
    s_bready = 1'b1; s_rready = 1'b1;

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_bvalid", 32'(s_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_awready", 32'(s_awready), 32'd1);
    chk("rst_wready", 32'(s_wready), 32'd1);
    chk("rst_arready", 32'(s_arready), 32'd1);
    axi_read(8'h04, rd);
    chk("rst_rd_04", rd, 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      end else begin
        axi_read(vecs[i].addr, rd);
        chk(vecs[i].nm, rd, vecs[i].exp);
      end
    end

    // Split channels: W first, AW three cycles later
    @(negedge clk);
    s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(negedge clk);
    s_wvalid = 1'b0;
    chk("split_wready_low", 32'(s_wready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("split_no_bvalid", 32'(s_bvalid), 32'd0);
    end
    s_awaddr = 8'h20; s_awvalid = 1'b1;
    chk("split_awready", 32'(s_awready), 32'd1);
    @(negedge clk);
    s_awvalid = 1'b0;
    chk("split_bvalid", 32'(s_bvalid), 32'd1);
    axi_read(8'h20, rd);
    chk("split_rd_20", rd, 32'h12345678);

    // Split channels: AW first, W one cycle later
    @(negedge clk);
    s_awaddr = 8'h24; s_awvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0;
    chk("awfirst_awready_low", 32'(s_awready), 32'd0);
    chk("awfirst_no_bvalid", 32'(s_bvalid), 32'd0);
    s_wdata = 32'h0F0F0F0F; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(negedge clk);
    s_wvalid = 1'b0;
    chk("awfirst_bvalid", 32'(s_bvalid), 32'd1);
    axi_read(8'h24, rd);
    chk("awfirst_rd_24", rd, 32'h0F0F0F0F);

    // Write response backpressure
    s_bready = 1'b0;
    @(negedge clk);
    s_awaddr = 8'h30; s_wdata = 32'hA5A5A5A5; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid_hold", 32'(s_bvalid), 32'd1);
      chk("bp_awready_low", 32'(s_awready), 32'd0);
      chk("bp_wready_low", 32'(s_wready), 32'd0);
      @(negedge clk);
    end
    s_bready = 1'b1;
    @(negedge clk);
    chk("bp_bvalid_clear", 32'(s_bvalid), 32'd0);
    chk("bp_awready_back", 32'(s_awready), 32'd1);

    // Read data backpressure
    s_rready = 1'b0;
    s_araddr = 8'h30; s_arvalid = 1'b1;
    @(negedge clk);
    s_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid_hold", 32'(s_rvalid), 32'd1);
      chk("bp_rdata_hold", s_rdata, 32'hA5A5A5A5);
      chk("bp_arready_low", 32'(s_arready), 32'd0);
      @(negedge clk);
    end
    s_rready = 1'b1;
    @(negedge clk);
    chk("bp_rvalid_clear", 32'(s_rvalid), 32'd0);
    chk("bp_arready_back", 32'(s_arready), 32'd1);
    axi_write(8'h34, 32'h600DF00D, 4'hF);
    axi_read(8'h34, rd);
    chk("bp_after_rd_34", rd, 32'h600DF00D);

    // Same-edge read and write of 0x08 (holds 0x1)
    @(negedge clk);
    s_awaddr = 8'h08; s_wdata = 32'h00000077; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    s_araddr = 8'h08; s_arvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    chk("rw_same_rvalid", 32'(s_rvalid), 32'd1);
    chk("rw_same_old_value", s_rdata, 32'h00000001);
    chk("rw_same_bvalid", 32'(s_bvalid), 32'd1);
    axi_read(8'h08, rd);
    chk("rw_same_new_value", rd, 32'h00000077);

    // Reset with W held: buffer and registers discarded
    @(negedge clk);
    s_wdata = 32'hFFFFFFFF; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(negedge clk);
    s_wvalid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_wready", 32'(s_wready), 32'd1);
    axi_read(8'h10, rd);
    chk("midrst_rd_10", rd, 32'd0);
    @(negedge clk);
    s_awaddr = 8'h10; s_awvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0;
    @(negedge clk);
    chk("midrst_no_bvalid", 32'(s_bvalid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
